// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the data-memory arbiter
package mem_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LD  = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// rtl/dmem_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
  import mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  // On contention the port that was not granted most recently wins.
  always_comb begin
    win = 2'b00;
    if (req == 2'b11) begin
      win = (last == PORT_LD) ? 2'b01 : 2'b10;
    end else begin
      win = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter for a single-port data memory
module dmem_arbiter
  import mem_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int HOLD_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  input  logic [DW-1:0] mem_rd
);

  localparam int HW = $clog2(HOLD_MAX + 1);

  arb_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          last_q, last_d;
  logic          rsel_q, rsel_d;
  logic          rpend_q, rpend_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic [1:0]    pick;
  logic          hold_full;

  rr_pick2 u_pick (
    .req  ({req1, req0}),
    .last (last_q),
    .win  (pick)
  );

  assign hold_full = (hold_cnt_q == HW'(HOLD_MAX));

  // Ownership FSM: grant decision, next state and hold counter.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        gnt0       = pick[0];
        gnt1       = pick[1];
        hold_cnt_d = '0;
        // Only the winner's lock counts; a losing lock waits for its own win.
        if (pick[0] && lock0) begin
          state_d    = ARB_OWN0;
          hold_cnt_d = HW'(1);
        end else if (pick[1] && lock1) begin
          state_d    = ARB_OWN1;
          hold_cnt_d = HW'(1);
        end
      end
      ARB_OWN0: begin
        if (req0 && !(hold_full && req1)) begin
          gnt0 = 1'b1;
        end else if (req1) begin
          gnt1 = 1'b1;
        end
        if (!req0 || !lock0 || (hold_full && req1)) begin
          state_d    = ARB_IDLE;
          hold_cnt_d = '0;
        end else if (!hold_full) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ARB_OWN1: begin
        if (req1 && !(hold_full && req0)) begin
          gnt1 = 1'b1;
        end else if (req0) begin
          gnt0 = 1'b1;
        end
        if (!req1 || !lock1 || (hold_full && req0)) begin
          state_d    = ARB_IDLE;
          hold_cnt_d = '0;
        end else if (!hold_full) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d    = ARB_IDLE;
        hold_cnt_d = '0;
      end
    endcase
  end

  // Memory-side mux: the granted port drives the memory, idle bus is all zero.
  always_comb begin
    mem_en = gnt0 | gnt1;
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (gnt0) begin
      mem_we = we0;
      mem_a  = addr0;
      mem_wd = wdata0;
    end else if (gnt1) begin
      mem_we = we1;
      mem_a  = addr1;
      mem_wd = wdata1;
    end
  end

  // Round-robin history and read-return bookkeeping captured at grant time.
  always_comb begin
    last_d  = last_q;
    rsel_d  = rsel_q;
    rpend_d = 1'b0;
    if (mem_en) begin
      last_d  = gnt1;
      rsel_d  = gnt1;
      rpend_d = ~mem_we;
    end
  end

  // Read data passes straight through while valid and is held afterwards.
  always_comb begin
    rvalid0  = rpend_q && (rsel_q == PORT_CPU);
    rvalid1  = rpend_q && (rsel_q == PORT_LD);
    rdata0   = rvalid0 ? mem_rd : rdata0_q;
    rdata1   = rvalid1 ? mem_rd : rdata1_q;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
  end

  // State registers; reset drops any in-flight read return.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      hold_cnt_q <= '0;
      last_q     <= PORT_LD;
      rsel_q     <= PORT_CPU;
      rpend_q    <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      last_q     <= last_d;
      rsel_q     <= rsel_d;
      rpend_q    <= rpend_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

endmodule
